// File: rtl/acc_stream_pkg.sv
// Shared definitions for the acc_stream accumulator: mode encodings, FSM states, lane helpers.
// Used by both build variants (ACC_STREAM_SATURATE_EN defined or not).
package acc_stream_pkg;

  localparam logic ACC_MODE_SUM = 1'b0;
  localparam logic ACC_MODE_MAX = 1'b1;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;

  // Sign-extend the low w bits of v to 64 bits (w <= 64).
  function automatic logic signed [63:0] sext64(input logic [63:0] v, input int unsigned w);
    logic [63:0] sh;
    sh = v << (64 - w);
    return $signed(sh) >>> (64 - w);
  endfunction

  // Clamp a signed 64-bit value to the signed range of a w-bit lane.
  function automatic logic signed [63:0] sat64(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/acc_stream_lane.sv
// One accumulator lane: pass-0 select, sum/max combine and output narrowing.
// ACC_STREAM_SATURATE_EN selects clamping instead of wrapping on the narrowed output.
module acc_stream_lane
  import acc_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                  first,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] in_lane,
  input  logic [ACC_WIDTH-1:0]  acc_prev,
  output logic [ACC_WIDTH-1:0]  acc_c,
  output logic [DATA_WIDTH-1:0] out_c
);

  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] prev_s;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] mx;

  always_comb begin
    in_ext = ACC_WIDTH'(sext64(64'(in_lane), DATA_WIDTH));
    prev_s = $signed(acc_prev);
    sum    = prev_s + in_ext;
    mx     = (prev_s > in_ext) ? prev_s : in_ext;
    if (first)                    acc_c = in_ext;
    else if (mode == ACC_MODE_MAX) acc_c = mx;
    else                          acc_c = sum;
`ifdef ACC_STREAM_SATURATE_EN
    out_c = DATA_WIDTH'(sat64(sext64(64'(acc_c), ACC_WIDTH), DATA_WIDTH));
`else
    out_c = acc_c[DATA_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/acc_stream.sv
// Multi-pass sum/max stream accumulator with an inferred buffer and a backpressured result register.
// Output narrowing clamps when ACC_STREAM_SATURATE_EN is defined, otherwise wraps.
module acc_stream
  import acc_stream_pkg::*;
#(
  parameter int unsigned NUM_INPUTS             = 8,
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned ACC_WIDTH              = 24,
  parameter int unsigned DEPTH                  = 1024,
  parameter int unsigned LOG_MAX_ITERS          = 16,
  parameter int unsigned LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 configure,
  input  logic [LOG_MAX_ITERS-1:0]             num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]    num_reads_per_iter,
  input  logic                                 mode,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     data_in,
  input  logic                                 valid_in,
  output logic                                 avail_out,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]     data_out,
  output logic                                 valid_out,
  input  logic                                 avail_in,
  output logic                                 busy
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IN_W   = NUM_INPUTS * DATA_WIDTH;
  localparam int unsigned BUF_W  = NUM_INPUTS * ACC_WIDTH;
  localparam int unsigned IT_W   = LOG_MAX_ITERS;
  localparam int unsigned RD_W   = LOG_MAX_READS_PER_ITER;

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   next_state;
  logic              accept;
  logic              cfg_ok;
  logic [IT_W-1:0]   n_r;
  logic [RD_W-1:0]   r_r;
  logic              mode_r;
  logic [IT_W-1:0]   it;
  logic [RD_W-1:0]   rd;
  logic [ADDR_W-1:0] addr;
  logic              last_pass;
  logic              last_rd;
  logic              out_free;

  logic              s1_valid;
  logic              s1_first;
  logic              s1_final;
  logic [ADDR_W-1:0] s1_addr;
  logic [IN_W-1:0]   s1_in;
  logic              fwd_hit;
  logic [BUF_W-1:0]  fwd_data;
  logic [BUF_W-1:0]  rdata;
  logic [BUF_W-1:0]  prev;
  logic [BUF_W-1:0]  acc_comb;
  logic [IN_W-1:0]   out_comb;
  logic              wr_en;

  logic [BUF_W-1:0]  mem [DEPTH];

  assign last_pass = (it == n_r - IT_W'(1));
  assign last_rd   = (rd == r_r - RD_W'(1));
  assign addr      = ADDR_W'(32'(rd) % DEPTH);
  assign out_free  = !valid_out || avail_in;
  assign wr_en     = s1_valid && !s1_final;
  assign prev      = fwd_hit ? fwd_data : rdata;

  // Next state, acceptance and flow control
  always_comb begin
    next_state = state;
    avail_out  = 1'b0;
    accept     = 1'b0;
    cfg_ok     = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ok = configure && (num_iters != '0) && (num_reads_per_iter != '0);
        if (cfg_ok) next_state = ST_RUN;
      end
      ST_RUN: begin
        // Final-pass beats are only taken when their result has a guaranteed slot.
        if (last_pass) avail_out = out_free && !(s1_valid && s1_final);
        else           avail_out = 1'b1;
        accept = valid_in && avail_out;
        if (accept && last_rd && last_pass) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid && out_free) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_r    <= '0;
      r_r    <= '0;
      mode_r <= ACC_MODE_SUM;
      it     <= '0;
      rd     <= '0;
    end else if (cfg_ok) begin
      n_r    <= num_iters;
      r_r    <= num_reads_per_iter;
      mode_r <= mode;
      it     <= '0;
      rd     <= '0;
    end else if (accept) begin
      if (last_rd) begin
        rd <= '0;
        it <= it + IT_W'(1);
      end else begin
        rd <= rd + RD_W'(1);
      end
    end
  end

  // Stage 1 registers; fwd_* covers a same-address write/read in one cycle (R == 1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_final <= 1'b0;
      s1_addr  <= '0;
      s1_in    <= '0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= (it == '0);
        s1_final <= last_pass;
        s1_addr  <= addr;
        s1_in    <= data_in;
      end
      fwd_hit  <= accept && wr_en && (s1_addr == addr);
      fwd_data <= acc_comb;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)  mem[s1_addr] <= acc_comb;
    if (accept) rdata        <= mem[addr];
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    acc_stream_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .first    (s1_first),
      .mode     (mode_r),
      .in_lane  (s1_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .acc_prev (prev[i*ACC_WIDTH +: ACC_WIDTH]),
      .acc_c    (acc_comb[i*ACC_WIDTH +: ACC_WIDTH]),
      .out_c    (out_comb[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Result register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (s1_valid && s1_final) begin
      valid_out <= 1'b1;
      data_out  <= out_comb;
    end else if (avail_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_stream.sv
// Directed self-checking bench for acc_stream; expectations follow ACC_STREAM_SATURATE_EN when defined.
module tb_acc_stream;

  localparam int NI = 8;
  localparam int DW = 8;

`ifdef ACC_STREAM_SATURATE_EN
  localparam int SAT_EXP = 127;
`else
  localparam int SAT_EXP = -56;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            configure = 1'b0;
  logic [15:0]     num_iters = '0;
  logic [15:0]     num_reads_per_iter = '0;
  logic            mode = 1'b0;
  logic [NI*DW-1:0] data_in = '0;
  logic            valid_in = 1'b0;
  logic            avail_out;
  logic [NI*DW-1:0] data_out;
  logic            valid_out;
  logic            avail_in = 1'b1;
  logic            busy;

  always #5 clk = ~clk;

  acc_stream #(
    .NUM_INPUTS(NI), .DATA_WIDTH(DW), .ACC_WIDTH(24), .DEPTH(1024),
    .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .mode(mode), .data_in(data_in),
    .valid_in(valid_in), .avail_out(avail_out), .data_out(data_out),
    .valid_out(valid_out), .avail_in(avail_in), .busy(busy)
  );

  int n_vec = 0;
  int n_fail = 0;
  int q0[$];
  int q7[$];
  int stable_err = 0;
  int busy_at_pop = 0;
  bit stall_seen = 1'b0;
  bit held_prev = 1'b0;
  logic [NI*DW-1:0] data_prev = '0;

  // Capture popped results and watch the output register under backpressure
  always @(negedge clk) begin
    if (rst) begin
      if (valid_out && avail_in) begin
        q0.push_back(int'($signed(data_out[7:0])));
        q7.push_back(int'($signed(data_out[63:56])));
        busy_at_pop = int'(busy);
      end
      if (held_prev && (!valid_out || data_out !== data_prev)) stable_err++;
      if (!avail_in && valid_out && busy && !avail_out) stall_seen = 1'b1;
      held_prev = valid_out && !avail_in;
      data_prev = data_out;
    end else begin
      held_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input int n, input int r, input logic m);
    configure = 1'b1;
    num_iters = 16'(n);
    num_reads_per_iter = 16'(r);
    mode = m;
    @(posedge clk); #1;
    configure = 1'b0;
  endtask

  task automatic send(input int l0, input int l7);
    int n;
    n = 0;
    data_in = '0;
    data_in[7:0] = 8'(l0);
    data_in[63:56] = 8'(l7);
    valid_in = 1'b1;
    @(negedge clk);
    while (!avail_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_accepted", 32'(n < 100), 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD;
  endfunction

  initial begin
    #12;
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_avail_out", 32'(avail_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data_lo", data_out[31:0], 0);
    check("rst_data_hi", data_out[63:32], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-length jobs are refused
    cfg(0, 4, 1'b0);
    check("cfg_n0_idle", 32'(busy), 0);
    cfg(3, 0, 1'b0);
    check("cfg_r0_idle", 32'(busy), 0);

    // N=3 R=4 sum
    q0.delete(); q7.delete();
    cfg(3, 4, 1'b0);
    check("cfg_busy", 32'(busy), 1);
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++) send(b + 1, -(b + 1));
    wait_idle();
    check("t1_count", q0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_lane0", at(q0, i), 3 * (i + 1));
      check("t1_lane7", at(q7, i), -3 * (i + 1));
    end
    check("t1_busy_at_last", busy_at_pop, 1);

    // N=2 R=1 back-to-back, forwarding path
    q0.delete(); q7.delete();
    cfg(2, 1, 1'b0);
    send(5, 0);
    send(7, 0);
    wait_idle();
    check("t2_count", q0.size(), 1);
    check("t2_bypass", at(q0, 0), 12);

    // N=4 R=2 max
    q0.delete(); q7.delete();
    cfg(4, 2, 1'b1);
    send(-3, 0); send(10, 0);
    send(8, 0);  send(-20, 0);
    send(-1, 0); send(4, 0);
    send(2, 0);  send(2, 0);
    wait_idle();
    check("t3_count", q0.size(), 2);
    check("t3_max0", at(q0, 0), 8);
    check("t3_max1", at(q0, 1), 10);

    // Narrowing of 200
    q0.delete(); q7.delete();
    cfg(2, 1, 1'b0);
    send(100, 0);
    send(100, 0);
    wait_idle();
    check("t4_count", q0.size(), 1);
    check("t4_narrow", at(q0, 0), SAT_EXP);

    // N=1 R=8 pass-through with a 5-cycle consumer stall
    q0.delete(); q7.delete();
    stable_err = 0;
    stall_seen = 1'b0;
    cfg(1, 8, 1'b0);
    fork
      for (int i = 0; i < 8; i++) send(3 * i - 7, i);
      begin
        repeat (3) @(posedge clk);
        #2 avail_in = 1'b0;
        repeat (5) @(posedge clk);
        #2 avail_in = 1'b1;
      end
    join
    wait_idle();
    check("t5_count", q0.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("t5_lane0", at(q0, i), 3 * i - 7);
      check("t5_lane7", at(q7, i), i);
    end
    check("t5_stall_seen", 32'(stall_seen), 1);
    check("t5_held_stable", stable_err, 0);

    // Reset during pass 1, then a fresh pass-through job
    q0.delete(); q7.delete();
    cfg(3, 2, 1'b0);
    send(1, 0);
    send(2, 0);
    send(3, 0);
    rst = 1'b0;
    #1;
    check("t6_rst_valid_out", 32'(valid_out), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_avail_out", 32'(avail_out), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_no_stale", q0.size(), 0);
    cfg(1, 2, 1'b0);
    send(9, 0);
    send(-9, 0);
    wait_idle();
    check("t6_count", q0.size(), 2);
    check("t6_out0", at(q0, 0), 9);
    check("t6_out1", at(q0, 1), -9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/acc_stream.md
Name: acc_stream

Overview:
- Parametrised successor accumulator for the systolic output path.
- Accumulates NUM_INPUTS signed lanes over num_iters passes of num_reads_per_iter beats, using an internal BRAM-style buffer of DEPTH words.
- Selectable sum or max reduction.
- Emits the reduced result only during the final pass; it sits between the conv/add stages and the writer.

Parameters:
- NUM_INPUTS, 8, lanes per beat (outputs == inputs)
- DATA_WIDTH, 8, signed lane width in and out
- ACC_WIDTH, 24, signed internal accumulator lane width (>= DATA_WIDTH)
- DEPTH, 1024, buffer words (max reads per iteration)
- LOG_MAX_ITERS, 16, width of num_iters
- LOG_MAX_READS_PER_ITER, 16, width of num_reads_per_iter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- configure  in  1  configure strobe, honoured only in IDLE
- num_iters  in  LOG_MAX_ITERS  passes (N)
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  beats per pass (R)
- mode  in  1  0 = sum, 1 = signed max
- data_in  in  NUM_INPUTS*DATA_WIDTH  input lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- valid_in  in  1  input valid
- avail_out  out  1  block can accept a beat
- data_out  out  NUM_INPUTS*DATA_WIDTH  result lanes
- valid_out  out  1  result valid
- avail_in  in  1  downstream ready
- busy  out  1  not IDLE

Behaviour:
- Reset: rst low asynchronously forces:
  - state IDLE
  - counters 0
  - valid_out 0, avail_out 0, busy 0
  - data_out 0
  - buffer contents don't-care
- Reset mid-operation aborts the job; no partial output is produced.
- States:
  - IDLE: configure with N>0 and R>0 latches N, R, mode and goes to RUN. configure with N==0 or R==0 stays IDLE.
  - RUN: beats are accepted.
  - DRAIN: after the last beat of the last pass, wait until the result register empties, then go to IDLE.
- Transfer on valid_in && avail_out. Counters rd (0..R-1) and it (0..N-1); rd wraps to 0 and it increments at rd==R-1.
- R > DEPTH is illegal. The buffer address is rd modulo DEPTH; verification must not drive it.
- Pipeline:
  - Stage 0: accept beat, issue buffer read at rd.
  - Stage 1: buffer data returns; combine and write back, or present to the output.
- Combine:
  - Pass 0: operand is the input sign-extended to ACC_WIDTH. The buffer value is ignored.
  - Later passes: sum mode adds with ACC_WIDTH wrap; max mode takes the signed max.
- Bypass: if stage 1 writes the address stage 0 reads in the same cycle (R==1), the new value is forwarded. The result must equal the hazard-free result.
- Final pass (it==N-1): the combined value goes to the output register, not the buffer. Output narrowing is covered under Optional Feature. N==1 passes the input straight through.
- Output register:
  - valid_out and data_out are stable while valid_out && !avail_in.
  - valid_out clears on avail_in when no new result arrives that cycle.
  - Register latency: the final-pass beat appears 2 cycles after acceptance.
- avail_out:
  - RUN and not final pass: 1.
  - RUN and final pass: 1 only if the output register will be free next cycle (!valid_out || avail_in) and stage 1 holds no result. This gives no result loss under backpressure.
  - IDLE or DRAIN: 0.
- busy is 1 in RUN and DRAIN.
- configure outside IDLE is ignored.

Optional Feature:
- Macro ACC_STREAM_SATURATE_EN.
- Defined: output lanes clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: output is the low DATA_WIDTH bits of the accumulator (wrap).
- Internal accumulation is unaffected either way.

Decomposition:
- Shared package holds:
  - mode encodings ACC_MODE_SUM / ACC_MODE_MAX
  - state enum IDLE/RUN/DRAIN
  - lane sign-extend and saturate functions
- Natural sub-module: acc_stream_lane, one lane combining pass-0 select, sum/max and narrowing; instantiated NUM_INPUTS times.
- The buffer is inferred inside acc_stream.

Test Plan:
- N=3, R=4, sum, lane0 beats = 1,2,3,4 each pass, avail_in=1 -> lane0 outputs 3,6,9,12; exactly 4 valid_out pulses; busy drops after the last one.
- N=2, R=1, sum, back-to-back beats 5 then 7 -> single output 12, confirming bypass.
- N=4, R=2, max, lane0 sequence -3,10 / 8,-20 / -1,4 / 2,2 -> outputs 8,10.
- Sum, DATA_WIDTH=8, N=2, R=1, beats 100,100 -> output 127 with ACC_STREAM_SATURATE_EN, -56 without.
- N=1, R=8 with avail_in held low for 5 cycles mid-stream -> avail_out drops, no beat lost or duplicated, all 8 outputs in order.
- Assert rst mid-pass 1 of an N=3 job, then configure N=1, R=2 -> no stale output; new job passes inputs through.
